// File: rtl/systolic_result_writer_if.sv
// Result-drain bus: start/capture side plus the valid/ready output stream.
interface systolic_result_writer_if #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic                       cs;
  logic                       start;
  logic [ROW*COL*WIDTH-1:0]   result_in;
  logic                       out_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [AW-1:0]              out_addr;
  logic                       out_last;
  logic                       busy;
  logic                       done;

  // Controller / downstream side.
  modport master (
    output cs, start, result_in, out_ready,
    input  out_valid, out_data, out_addr, out_last, busy, done
  );

  // Writer side.
  modport slave (
    input  cs, start, result_in, out_ready,
    output out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/systolic_result_writer.sv
// Snapshots the flattened ROW x COL result matrix on start and streams it
// out row-major, one element per beat, over a registered valid/ready port.
module systolic_result_writer #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_result_writer_if.slave bus
);
  localparam int            N    = ROW * COL;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0][WIDTH-1:0] buf_q;

  logic             accept, xfer, xfer_last;
  logic [AW-1:0]    nxt_addr;
  logic [WIDTH-1:0] nxt_data;

  logic             valid_d, last_d, busy_d, done_d;
  logic [WIDTH-1:0] data_d;
  logic [AW-1:0]    addr_d;

  assign accept    = (state_q == IDLE) && bus.start && bus.cs;
  assign xfer      = (state_q == STREAM) && bus.out_valid && bus.out_ready;
  assign xfer_last = xfer && (bus.out_addr == LAST);
  assign nxt_addr  = bus.out_addr + AW'(1);

  // Element lookup for the following beat, read from the snapshot only.
  always_comb begin
    nxt_data = '0;
    for (int k = 0; k < N; k++)
      if (nxt_addr == AW'(k)) nxt_data = buf_q[k];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: starts outside IDLE are dropped, FIN lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = STREAM;
      STREAM:  if (xfer_last) state_d = FIN;
      FIN:                    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; hold by default so a stalled
  // beat keeps data/addr/last stable.
  always_comb begin
    valid_d = bus.out_valid;
    data_d  = bus.out_data;
    addr_d  = bus.out_addr;
    last_d  = bus.out_last;
    busy_d  = bus.busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        valid_d = 1'b1;
        data_d  = bus.result_in[WIDTH-1:0];
        addr_d  = '0;
        last_d  = (N == 1);
        busy_d  = 1'b1;
      end
      STREAM: if (xfer_last) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else if (xfer) begin
        data_d  = nxt_data;
        addr_d  = nxt_addr;
        last_d  = (nxt_addr == LAST);
      end
      default: ;
    endcase
  end

  // Output registers; reset aborts any stream without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.out_valid <= valid_d;
      bus.out_data  <= data_d;
      bus.out_addr  <= addr_d;
      bus.out_last  <= last_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
    end
  end

  // Snapshot buffer, loaded only on an accepted start so the array can
  // move on to its next tile while this one drains.
  always_ff @(posedge clk) begin
    if (rst)         buf_q <= '0;
    else if (accept) buf_q <= bus.result_in;
  end
endmodule

// File: tb/tb_systolic_result_writer.sv
// Directed bench for systolic_result_writer: a per-cycle vector table for
// full-rate and backpressured drains, plus hand sequences for the corners.
module tb_systolic_result_writer;
  localparam int ROW = 4, COL = 4, WIDTH = 16, AW = 4, N = ROW * COL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_result_writer_if #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH), .AW(AW)) bus();

  systolic_result_writer #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        cs, st, rdy;
    logic        v, l, b, dn;
    logic [15:0] data;
    logic [3:0]  addr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input logic [15:0] base);
    for (int k = 0; k < N; k++) bus.result_in[k*WIDTH +: WIDTH] = 16'(base + 16'(k));
  endtask

  function automatic void push(input logic cs, input logic st, input logic rdy,
                               input logic v, input logic [15:0] data, input int addr,
                               input logic l, input logic b, input logic dn);
    vec_t x;
    x.cs = cs; x.st = st; x.rdy = rdy;
    x.v = v; x.data = data; x.addr = 4'(addr); x.l = l; x.b = b; x.dn = dn;
    vecs.push_back(x);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"},  bus.busy,      0);
    chk({tag, "_done"},  bus.done,      0);
    chk({tag, "_last"},  bus.out_last,  0);
  endtask

  // Drain a stream already launched (beat 0 visible) at full rate. Optional
  // start pulses: at beat start_beat, and on the last transfer plus FIN cycle.
  task automatic drain(input logic [15:0] base, input int start_beat,
                       input bit fin_start, input string tag);
    int beats = 0;
    bit got   = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      bus.start = 1'b0;
      if (bus.out_valid) begin
        if (beats < N) begin
          chk($sformatf("%s_addr%0d", tag, beats), bus.out_addr, beats);
          chk($sformatf("%s_data%0d", tag, beats), bus.out_data, 16'(base + 16'(beats)));
          chk($sformatf("%s_last%0d", tag, beats), bus.out_last, (beats == N - 1));
          chk($sformatf("%s_busy%0d", tag, beats), bus.busy, 1);
        end
        if (beats == start_beat) bus.start = 1'b1;
        if (fin_start && beats == N - 1) bus.start = 1'b1;
        beats++;
      end
      step();
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_beats"}, beats, N);
    if (fin_start) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_quiet({tag, "_after_fin_start"});
    end else begin
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a, j;
    logic r;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Full-rate drain: start then 16 beats, done, back to idle.
    push(1, 1, 1, 1, 16'h0100, 0, 0, 1, 0);
    for (int i = 1; i < N; i++)
      push(1, 0, 1, 1, 16'(16'h0100 + 16'(i)), i, (i == N - 1), 1, 0);
    push(1, 0, 1, 0, 16'h0, 0, 0, 0, 1);
    push(1, 0, 1, 0, 16'h0, 0, 0, 0, 0);

    // Backpressure with ready pattern 1,0,0,1 from the first stream cycle.
    push(1, 1, 0, 1, 16'h0100, 0, 0, 1, 0);
    a = 0;
    j = 0;
    while (1) begin
      r = pat[j % 4];
      if (r && a == N - 1) begin
        push(1, 0, 1, 0, 16'h0, 0, 0, 0, 1);
        break;
      end
      if (r) a++;
      push(1, 0, r, 1, 16'(16'h0100 + 16'(a)), a, (a == N - 1), 1, 0);
      j++;
    end
    push(1, 0, 0, 0, 16'h0, 0, 0, 0, 0);

    // Reset then idle.
    rst = 1'b1;
    bus.cs = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.result_in = '0;
    step();
    step();
    chk_quiet("reset");
    chk("reset_addr", bus.out_addr, 0);
    chk("reset_data", bus.out_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_quiet($sformatf("idle%0d", i));
      chk($sformatf("idle%0d_addr", i), bus.out_addr, 0);
      chk($sformatf("idle%0d_data", i), bus.out_data, 0);
    end

    // Table-driven per-cycle vectors.
    set_ramp(16'h0100);
    foreach (vecs[i]) begin
      bus.cs        = vecs[i].cs;
      bus.start     = vecs[i].st;
      bus.out_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].v);
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].data);
        chk($sformatf("vec%0d_addr", i), bus.out_addr, vecs[i].addr);
      end
      chk($sformatf("vec%0d_last", i), bus.out_last, vecs[i].l);
      chk($sformatf("vec%0d_busy", i), bus.busy,     vecs[i].b);
      chk($sformatf("vec%0d_done", i), bus.done,     vecs[i].dn);
    end
    bus.start = 1'b0;

    // Snapshot isolation: input bus changes right after capture.
    set_ramp(16'h0000);
    bus.cs = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    bus.result_in = '1;
    drain(16'h0000, -1, 0, "snap");
    step();
    chk_quiet("snap_idle");

    // Ignored starts: cs=0, mid-stream, last transfer and FIN cycle.
    set_ramp(16'h0200);
    bus.cs = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_quiet("cs0_start");
    step();
    chk_quiet("cs0_start2");
    bus.cs = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.result_in = '1;
    drain(16'h0200, 5, 1, "ign");
    // First IDLE cycle after FIN: a start here launches a fresh stream.
    set_ramp(16'h0300);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drain(16'h0300, -1, 0, "restart");

    // Mid-stream reset after beat 5 transfers.
    step();
    set_ramp(16'h0400);
    bus.start = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_pre_addr", bus.out_addr, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_quiet("mid_rst");
    chk("mid_rst_addr", bus.out_addr, 0);
    chk("mid_rst_data", bus.out_data, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet($sformatf("mid_after%0d", i));
    end
    set_ramp(16'h0500);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drain(16'h0500, -1, 0, "mid_new");
    step();
    chk_quiet("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
